lsu_align_unit: RTL
===================

Name: lsu_align_unit

Overview:
- Load/store unit directly upstream of data_memory in the RISC-V datapath.
- Accepts one RV32I load/store request at a time from execute and generates the word-addressed memory accesses with byte enables.
- Splits misaligned accesses into two word accesses and merges the read data.
- Returns the sign- or zero-extended load result (or a store acknowledge) through a one-cycle response pulse.

Parameters:
- ADDR_W, 5: word-address width; 32 words, matching data memory depth.
- MISALIGN_EN, 1: 1 splits misaligned accesses; 0 flags them as errors with no memory access.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; reset=0 clears all state.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_be  out  4  byte enables, bit i = byte i.
- mem_wdata  out  32  lane-shifted store data.
- mem_rdata  in  32  read word; valid the cycle after a read access.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load result; 0 for stores and errors.
- rsp_err  out  1  illegal funct3, or misaligned access with MISALIGN_EN=0.
- busy  out  1  equals ~req_ready; drives the pipeline stall.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all outputs 0 except req_ready=1. Any in-flight access is abandoned. A split store interrupted after ACC0 leaves its first word written; no rollback.
- Accept: req_valid & req_ready at edge T latches we, funct3, addr and wdata.
- Decoded fields:
  - off = addr[1:0].
  - size mask: B=0001, H=0011, W=1111.
  - lo word = addr[ADDR_W+1:2]; upper address bits are ignored.
  - split = (off + bytes) > 4.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
- States and transitions:
  - IDLE -> ACC0 on accept.
  - IDLE -> RESP directly if illegal, or if split with MISALIGN_EN=0. rsp_err=1 in cycle T+1; no mem_en.
  - ACC0 (T+1): mem_en=1, mem_addr=lo word. Goes to ACC1 if split, else CAPT.
  - ACC1 (T+2): mem_en=1, mem_addr=(lo word+1) mod 2^ADDR_W (wraps). Captures mem_rdata as lo_data. Goes to CAPT.
  - CAPT: captures mem_rdata as the last word (lo_data if not split, else hi_data). Computes the result into rsp registers. Goes to RESP.
  - RESP: rsp_valid=1 for exactly one cycle. Goes to IDLE.
- Latency from accept:
  - Aligned: rsp_valid at T+3.
  - Split: rsp_valid at T+4.
  - Error: rsp_valid at T+1.
- Throughput: next accept no earlier than the cycle after RESP.
- Stores:
  - emask = mask << off (8 bits).
  - ACC0: be=emask[3:0], wdata = wdata << (8*off).
  - ACC1: be=emask[7:4], wdata = wdata >> (8*(4-off)).
  - mem_we=1 in both access cycles.
- Loads:
  - mem_we=0, mem_be=1111.
  - Result = ({hi_data, lo_data} >> (8*off)), truncated to the access size.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Outside access cycles: mem_en, mem_we and mem_be are 0. mem_addr and mem_wdata hold their last value.
- req_* inputs are ignored while busy.

Test Plan:
- Preload mem[0]=0x44332211, mem[1]=0x88776655. LW addr 0x0 -> single access mem_addr=0, be=1111; rsp_valid at T+3, rsp_rdata=0x44332211, rsp_err=0.
- Byte loads:
  - LB addr 0x3 -> 0x00000044.
  - LB addr 0x7 -> 0xFFFFFF88.
  - LBU addr 0x7 -> 0x00000088.
  - LH addr 0x6 -> 0xFFFF8877.
- Misaligned loads:
  - LW addr 0x2 -> accesses word 0 then word 1; rsp at T+4 = 0x66554433.
  - LH addr 0x3 -> 0x00005544.
- Misaligned store: SW 0xDEADBEEF at addr 0x1.
  - ACC0: addr 0, be=1110, wdata=0xADBEEF00.
  - ACC1: addr 1, be=0001, wdata=0x000000DE.
  - Result: mem[0]=0xADBEEF11, mem[1]=0x887766DE; ack rdata=0.
- Wrap and error paths:
  - LW addr 0x7E, ADDR_W=5 -> words 31 then 0.
  - funct3=011 -> rsp_err=1 at T+1, mem_en never high.
  - MISALIGN_EN=0, LW addr 0x2 -> rsp_err=1 at T+1.
- Async reset: drive reset=0 mid-cycle during ACC1 of a split store -> all outputs 0 immediately, req_ready=1; mem[0] already written, mem[1] unchanged. A new LW after release completes normally.

Source files
------------

// File: rtl/lsu_align_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align_unit_if
// Purpose  : Request, memory-side and response bundle of the load/store unit.
// Revision : 1.0
// ============================================================================
interface lsu_align_unit_if #(
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;

  // master: execute stage plus data memory; slave: the align unit itself
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_en, mem_we, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_en, mem_we, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/lsu_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align_unit
// Purpose  : RV32I load/store aligner: word accesses with byte enables,
//            misaligned split/merge, load extension, one-cycle response.
// Revision : 1.0
// ============================================================================
module lsu_align_unit #(
  parameter int ADDR_W      = 5,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  lsu_align_unit_if.slave bus
);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_ACC0 = 3'd1;
  localparam logic [2:0] c_ST_ACC1 = 3'd2;
  localparam logic [2:0] c_ST_CAPT = 3'd3;
  localparam logic [2:0] c_ST_RESP = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;

  logic              r_we;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic              r_split;
  logic [7:0]        r_emask;
  logic [31:0]       r_wdata_hi;
  logic [31:0]       r_lo_data;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic [1:0]        w_req_off;
  logic [1:0]        w_req_size;
  logic [3:0]        w_req_mask;
  logic [7:0]        w_req_emask;
  logic [63:0]       w_req_wide;
  logic [ADDR_W-1:0] w_req_word;
  logic              w_req_legal;
  logic              w_req_split;
  logic              w_req_err;
  logic              w_accept;
  logic              w_unused;

  logic              w_ready;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [3:0]        w_mem_be;
  logic              w_rsp_valid;

  logic [31:0]       w_ld_lo;
  logic [31:0]       w_ld_shift;
  logic [31:0]       w_ld_result;

  // ---------------------------------------------------------------- decode
  always_comb begin
    w_req_off  = bus.req_addr[1:0];
    w_req_size = bus.req_funct3[1:0];
    w_req_word = bus.req_addr[ADDR_W+1:2];

    case (w_req_size)
      2'b00:   w_req_mask = 4'b0001;
      2'b01:   w_req_mask = 4'b0011;
      default: w_req_mask = 4'b1111;
    endcase

    if (bus.req_we)
      w_req_legal = !bus.req_funct3[2] && (w_req_size != 2'b11);
    else
      w_req_legal = (w_req_size != 2'b11) && (bus.req_funct3 != 3'b110);

    case (w_req_size)
      2'b00:   w_req_split = 1'b0;
      2'b01:   w_req_split = (w_req_off == 2'd3);
      default: w_req_split = (w_req_off != 2'd0);
    endcase

    w_req_err   = !w_req_legal || (w_req_split && !MISALIGN_EN);
    w_req_emask = {4'b0000, w_req_mask} << w_req_off;
    // low half feeds ACC0, high half is the spill into the next word for ACC1
    w_req_wide  = {32'h0000_0000, bus.req_wdata} << {w_req_off, 3'b000};
  end

  assign w_accept = bus.req_valid && (r_state == c_ST_IDLE);
  assign w_unused = &{1'b0, bus.req_addr[31:ADDR_W+2]};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_accept) w_state_nxt = w_req_err ? c_ST_RESP : c_ST_ACC0;
      c_ST_ACC0: w_state_nxt = r_split ? c_ST_ACC1 : c_ST_CAPT;
      c_ST_ACC1: w_state_nxt = c_ST_CAPT;
      c_ST_CAPT: w_state_nxt = c_ST_RESP;
      c_ST_RESP: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready     = (r_state == c_ST_IDLE);
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_be    = 4'b0000;
    w_rsp_valid = 1'b0;
    case (r_state)
      c_ST_ACC0: begin
        w_mem_en = 1'b1;
        w_mem_we = r_we;
        w_mem_be = r_we ? r_emask[3:0] : 4'b1111;
      end
      c_ST_ACC1: begin
        w_mem_en = 1'b1;
        w_mem_we = r_we;
        w_mem_be = r_we ? r_emask[7:4] : 4'b1111;
      end
      c_ST_RESP: w_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- load merge
  always_comb begin
    w_ld_lo    = r_split ? r_lo_data : bus.mem_rdata;
    w_ld_shift = 32'({bus.mem_rdata, w_ld_lo} >> {r_off, 3'b000});
    case (r_funct3)
      3'b000:  w_ld_result = {{24{w_ld_shift[7]}},  w_ld_shift[7:0]};
      3'b001:  w_ld_result = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
      3'b100:  w_ld_result = {24'h00_0000, w_ld_shift[7:0]};
      3'b101:  w_ld_result = {16'h0000,    w_ld_shift[15:0]};
      default: w_ld_result = w_ld_shift;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_split     <= 1'b0;
      r_emask     <= 8'h00;
      r_wdata_hi  <= 32'h0;
      r_lo_data   <= 32'h0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_we        <= bus.req_we;
            r_funct3    <= bus.req_funct3;
            r_off       <= w_req_off;
            r_split     <= w_req_split;
            r_emask     <= w_req_emask;
            r_wdata_hi  <= w_req_wide[63:32];
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= w_req_err;
            if (!w_req_err) begin
              r_mem_addr <= w_req_word;
              if (bus.req_we) r_mem_wdata <= w_req_wide[31:0];
            end
          end
        end
        c_ST_ACC0: begin
          if (r_split) begin
            r_mem_addr <= r_mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (r_we) r_mem_wdata <= r_wdata_hi;
          end
        end
        c_ST_ACC1: r_lo_data <= bus.mem_rdata;
        c_ST_CAPT: if (!r_we) r_rsp_rdata <= w_ld_result;
        default: ;
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.busy      = !w_ready;
  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_be    = w_mem_be;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
